// File: rtl/bit_frame_timer_pkg.sv
// Shared types and constants for the bit-period / frame timer.
package bit_frame_timer_pkg;

    localparam int unsigned DIV_W_DEF   = 16;
    localparam int unsigned IDX_W_DEF   = 4;
    localparam int unsigned DEFAULT_DIV = 11;
    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned MIN_BITS    = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bit_frame_timer_if.sv
// Control/status bundle between the UART control FSM (master) and the frame timer (slave).
interface bit_frame_timer_if #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned IDX_W = 4
);

    logic             start;
    logic             abort;
    logic             enable;
    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] frame_bits;
    logic             busy;
    logic [IDX_W-1:0] bit_idx;
    logic             end_bit_time;
    logic             end_half_time;
    logic             frame_done;

    modport master (
        output start, abort, enable, div, frame_bits,
        input  busy, bit_idx, end_bit_time, end_half_time, frame_done
    );

    modport slave (
        input  start, abort, enable, div, frame_bits,
        output busy, bit_idx, end_bit_time, end_half_time, frame_done
    );

endinterface

// File: rtl/bit_period_counter.sv
// Runtime-period counter: wraps after `period` run cycles, decodes last and mid points.
module bit_period_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         run,
    input  logic [W-1:0] period,
    output logic         end_bit_c,
    output logic         end_half_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] last;
    logic [W-1:0] half;

    // period is clamped upstream to >= 2, so period-1 never wraps
    assign last       = period - W'(1);
    assign half       = last >> 1;
    assign end_bit_c  = run & (count_q == last);
    assign end_half_c = run & (count_q == half);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= end_bit_c ? '0 : count_q + W'(1);
        end
    end

endmodule

// File: rtl/bit_frame_timer.sv
// Frame-level bit timer: captures divisor/length on start, steps bit index, flags frame end.
module bit_frame_timer
    import bit_frame_timer_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF,
    parameter int unsigned DEFAULT_DIV = bit_frame_timer_pkg::DEFAULT_DIV
) (
    input logic          clk,
    input logic          rst_n,
    bit_frame_timer_if.slave bus
);

    state_t           state_q;
    logic             busy_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] len_q;

    logic             run_en;
    logic             end_bit_c;
    logic             end_half_c;
    logic             frame_done_c;
    logic             cnt_clear;
    logic [DIV_W-1:0] div_clamped;
    logic [IDX_W-1:0] len_clamped;
    logic [IDX_W-1:0] len_last;

    assign run_en      = (state_q == ST_RUN) & bus.enable;
    assign cnt_clear   = bus.abort | bus.start;
    assign div_clamped = (bus.div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.div;
    assign len_clamped = (bus.frame_bits == '0) ? IDX_W'(MIN_BITS) : bus.frame_bits;
    assign len_last    = len_q - IDX_W'(1);

    bit_period_counter #(
        .W (DIV_W)
    ) u_period (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .run        (run_en),
        .period     (div_q),
        .end_bit_c  (end_bit_c),
        .end_half_c (end_half_c)
    );

    assign frame_done_c = end_bit_c & (bit_idx_q == len_last);

    // Priority: abort > start (restart/resync) > frame end > bit advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            bit_idx_q <= '0;
            div_q     <= DIV_W'(DEFAULT_DIV);
            len_q     <= IDX_W'(MIN_BITS);
        end else if (bus.abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            bit_idx_q <= '0;
        end else if (bus.start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            bit_idx_q <= '0;
            div_q     <= div_clamped;
            len_q     <= len_clamped;
        end else if (frame_done_c) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            bit_idx_q <= '0;
        end else if (end_bit_c) begin
            bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
    end

    assign bus.busy          = busy_q;
    assign bus.bit_idx       = bit_idx_q;
    assign bus.end_bit_time  = end_bit_c;
    assign bus.end_half_time = end_half_c;
    assign bus.frame_done    = frame_done_c;

endmodule

// File: tb/tb_bit_frame_timer.sv
// Randomised + directed bench for bit_frame_timer with a frame-level reference model and scoreboard.
module tb_bit_frame_timer;

    localparam int unsigned DIV_W = 16;
    localparam int unsigned IDX_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bit_frame_timer_if #(.DIV_W(DIV_W), .IDX_W(IDX_W)) bus ();

    bit_frame_timer #(.DIV_W(DIV_W), .IDX_W(IDX_W), .DEFAULT_DIV(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        int idx;
        bit eb;
        bit eh;
        bit fd;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: a frame is just a count of enabled cycles since start.
    bit m_active = 1'b0;
    int m_div    = 11;
    int m_len    = 1;
    int m_el     = 0;

    task automatic chk(input string name, input int act, input int exp, input int c);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit ab, input bit en,
                        input int dv, input int fb);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rst;
        bus.start      = st;
        bus.abort      = ab;
        bus.enable     = en;
        bus.div        = DIV_W'(dv);
        bus.frame_bits = IDX_W'(fb);
        if (!rst) begin
            m_active = 1'b0;
            m_div    = 11;
            m_len    = 1;
            m_el     = 0;
        end
        e.busy = m_active;
        e.idx  = m_active ? m_el / m_div : 0;
        e.eb   = m_active && en && ((m_el % m_div) == m_div - 1);
        e.eh   = m_active && en && ((m_el % m_div) == (m_div - 1) / 2);
        e.fd   = e.eb && ((m_el / m_div) == m_len - 1);
        e.cyc  = cyc;
        q.push_back(e);
        if (!rst) begin
            // already at reset values
        end else if (ab) begin
            m_active = 1'b0;
            m_el     = 0;
        end else if (st) begin
            m_active = 1'b1;
            m_div    = (dv < 2) ? 2 : dv;
            m_len    = (fb == 0) ? 1 : fb;
            m_el     = 0;
        end else if (m_active && en) begin
            m_el++;
            if (m_el == m_div * m_len) begin
                m_active = 1'b0;
                m_el     = 0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n, input bit en, input int dv);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, en, dv, 0);
    endtask

    // Monitor: compares one queued expectation per cycle at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("busy",          int'(bus.busy),          int'(e.busy), e.cyc);
                chk("bit_idx",       int'(bus.bit_idx),       e.idx,        e.cyc);
                chk("end_bit_time",  int'(bus.end_bit_time),  int'(e.eb),   e.cyc);
                chk("end_half_time", int'(bus.end_half_time), int'(e.eh),   e.cyc);
                chk("frame_done",    int'(bus.frame_done),    int'(e.fd),   e.cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.enable     = 1'b0;
        bus.div        = '0;
        bus.frame_bits = '0;

        // reset state
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, 10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, 10);
        run(3, 1'b1, 4);

        // full frame, div=4, 10 bits
        step(1'b1, 1'b1, 1'b0, 1'b1, 4, 10);
        run(44, 1'b1, 4);

        // div=5 mid point; div=0/1 clamp to 2; frame_bits=0 clamps to 1
        step(1'b1, 1'b1, 1'b0, 1'b1, 5, 2);
        run(12, 1'b1, 5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 0, 1);
        run(4, 1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1, 0);
        run(4, 1'b1, 1);

        // enable toggling every cycle
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 2);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, (i % 2) == 0, 3, 2);

        // restart mid-frame, then abort+start together
        step(1'b1, 1'b1, 1'b0, 1'b1, 6, 8);
        run(20, 1'b1, 6);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 2);
        run(8, 1'b1, 3);
        step(1'b1, 1'b1, 1'b0, 1'b1, 5, 4);
        run(3, 1'b1, 5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 7, 3);
        run(4, 1'b1, 7);

        // start on the frame_done cycle
        step(1'b1, 1'b1, 1'b0, 1'b1, 2, 2);
        run(3, 1'b1, 2);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 1);
        run(4, 1'b1, 3);

        // div input changes mid-frame are ignored
        step(1'b1, 1'b1, 1'b0, 1'b1, 4, 3);
        run(14, 1'b1, 8);

        // async reset mid-frame, then fresh start
        step(1'b1, 1'b1, 1'b0, 1'b1, 4, 5);
        run(7, 1'b1, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, 5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, 5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 3, 1);
        run(5, 1'b1, 3);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 499) != 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 7)));
        end
        run(2, 1'b1, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drain", q.size(), 0, cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
